// File: rtl/vend_dispense_sched_pkg.sv
// Shared definitions for the vending dispense scheduler:
// sequencing state encodings, sale codes and a small sizing helper.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_DISP  = 3'd2,
        ST_CHG   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] AMT_EXACT = 2'b00;
    localparam logic [1:0] AMT_CHG   = 2'b01;

    // Largest of three cycle limits, used to size the shared cycle counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vend_dispense_sched_if.sv
// Lane/mechanism side bundle of the dispense scheduler.
// master: the lane panels and mechanism environment; slave: the scheduler.
interface vend_dispense_sched_if #(
    parameter int N_LANE = 4
);
    logic [N_LANE-1:0]   req;
    logic [2*N_LANE-1:0] amt;
    logic                mech_ready;
    logic [N_LANE-1:0]   gnt;
    logic [N_LANE-1:0]   ack;
    logic                motor_on;
    logic                change_on;
    logic                busy;
    logic                err;

    modport master (
        output req, amt, mech_ready,
        input  gnt, ack, motor_on, change_on, busy, err
    );

    modport slave (
        input  req, amt, mech_ready,
        output gnt, ack, motor_on, change_on, busy, err
    );
endinterface

// File: rtl/vend_dispense_sched_rr_arb.sv
// Combinational round-robin pick: first requesting lane at or after ptr,
// wrapping from the last lane back to lane 0.
module vend_rr_arb #(
    parameter int N_LANE = 4
) (
    input  logic [N_LANE-1:0]         req,
    input  logic [$clog2(N_LANE)-1:0] ptr,
    output logic [N_LANE-1:0]         pick,
    output logic [$clog2(N_LANE)-1:0] pick_idx,
    output logic                      valid
);
    localparam int IDX_W = $clog2(N_LANE);

    logic [IDX_W-1:0] lane_s;
    logic             hit_s;

    // Scan lanes in priority order starting at the pointer; first requester wins
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        lane_s   = '0;
        hit_s    = 1'b0;
        for (int off = 0; off < N_LANE; off++) begin
            lane_s       = IDX_W'((int'(ptr) + off) % N_LANE);
            hit_s        = req[lane_s] & ~valid;
            pick[lane_s] = hit_s;
            pick_idx     = hit_s ? lane_s : pick_idx;
            valid        = valid | hit_s;
        end
    end
endmodule

// File: rtl/vend_dispense_sched.sv
// Dispense scheduler: shares one motor/change mechanism between N_LANE panels.
// Round-robin grant, then GRANT -> DISP -> (CHG) -> DONE sequencing with ack.
// Optional feature macro: VEND_TIMEOUT_EN (abort GRANT after TMO_CYC cycles
// of mech_ready low, pulsing err with ack). Without it GRANT waits forever.
module vend_dispense_sched
    import vend_pkg::*;
#(
    parameter int N_LANE   = 4,
    parameter int DISP_CYC = 8,
    parameter int CHG_CYC  = 4,
    parameter int TMO_CYC  = 255
) (
    input logic                  clk,
    input logic                  rst,
    vend_dispense_sched_if.slave bus
);
    localparam int IDX_W = $clog2(N_LANE);
    localparam int CNT_W = $clog2(max3(DISP_CYC, CHG_CYC, TMO_CYC) + 1);

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]    ptr_r, ptr_nxt_s;
    logic [IDX_W-1:0]    idx_r, idx_nxt_s;
    logic [N_LANE-1:0]   sel_r, sel_nxt_s;
    logic [1:0]          code_r, code_nxt_s;

    logic [N_LANE-1:0]   arb_pick_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic                arb_valid_s;

    logic [N_LANE-1:0]   gnt_nxt_s, ack_nxt_s;
    logic                motor_nxt_s, change_nxt_s, busy_nxt_s, err_nxt_s;
`ifdef VEND_TIMEOUT_EN
    logic                tmo_s;
`endif

    vend_rr_arb #(.N_LANE(N_LANE)) u_arb (
        .req      (bus.req),
        .ptr      (ptr_r),
        .pick     (arb_pick_s),
        .pick_idx (arb_idx_s),
        .valid    (arb_valid_s)
    );

    // State register with cycle counter and latched grant context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            ptr_r   <= '0;
            idx_r   <= '0;
            sel_r   <= '0;
            code_r  <= AMT_EXACT;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ptr_r   <= ptr_nxt_s;
            idx_r   <= idx_nxt_s;
            sel_r   <= sel_nxt_s;
            code_r  <= code_nxt_s;
        end
    end

    // Next-state logic: arbitration in IDLE, timed phases, pointer advance in DONE
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ptr_nxt_s   = ptr_r;
        idx_nxt_s   = idx_r;
        sel_nxt_s   = sel_r;
        code_nxt_s  = code_r;
`ifdef VEND_TIMEOUT_EN
        tmo_s       = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = '0;
                if (arb_valid_s) begin
                    state_nxt_s = ST_GRANT;
                    idx_nxt_s   = arb_idx_s;
                    sel_nxt_s   = arb_pick_s;
                    code_nxt_s  = bus.amt[{arb_idx_s, 1'b0} +: 2];
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (bus.mech_ready) begin
                    state_nxt_s = ST_DISP;
                    cnt_nxt_s   = '0;
`ifdef VEND_TIMEOUT_EN
                end else if (cnt_r == CNT_W'(TMO_CYC - 1)) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = '0;
                    tmo_s       = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
`else
                end else begin
                    state_nxt_s = ST_GRANT;
                end
`endif
            end
            ST_DISP: begin
                if (cnt_r == CNT_W'(DISP_CYC - 1)) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = (code_r == AMT_CHG) ? ST_CHG : ST_DONE;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_CHG: begin
                if (cnt_r == CNT_W'(CHG_CYC - 1)) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
                ptr_nxt_s   = (idx_r == IDX_W'(N_LANE - 1)) ? '0 : idx_r + IDX_W'(1);
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a clean register
    always_comb begin
        gnt_nxt_s    = '0;
        ack_nxt_s    = '0;
        motor_nxt_s  = 1'b0;
        change_nxt_s = 1'b0;
        busy_nxt_s   = 1'b0;
        err_nxt_s    = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_GRANT: begin
                gnt_nxt_s  = sel_nxt_s;
                busy_nxt_s = 1'b1;
            end
            ST_DISP: begin
                gnt_nxt_s   = sel_nxt_s;
                busy_nxt_s  = 1'b1;
                motor_nxt_s = 1'b1;
            end
            ST_CHG: begin
                gnt_nxt_s    = sel_nxt_s;
                busy_nxt_s   = 1'b1;
                change_nxt_s = 1'b1;
            end
            ST_DONE: begin
                gnt_nxt_s  = sel_nxt_s;
                ack_nxt_s  = sel_nxt_s;
                busy_nxt_s = 1'b1;
`ifdef VEND_TIMEOUT_EN
                err_nxt_s  = tmo_s;
`else
                err_nxt_s  = 1'b0;
`endif
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers; async reset drops the actuators immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gnt       <= '0;
            bus.ack       <= '0;
            bus.motor_on  <= 1'b0;
            bus.change_on <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.gnt       <= gnt_nxt_s;
            bus.ack       <= ack_nxt_s;
            bus.motor_on  <= motor_nxt_s;
            bus.change_on <= change_nxt_s;
            bus.busy      <= busy_nxt_s;
            bus.err       <= err_nxt_s;
        end
    end
endmodule

// File: tb/tb_vend_dispense_sched.sv
// Scoreboard bench for vend_dispense_sched: lane emulation drives requests,
// a round-robin reference model predicts the service sequence, and a monitor
// checks each acknowledged transaction against the queued expectation.
module tb_vend_dispense_sched;
    localparam int N    = 4;
    localparam int DISP = 8;
    localparam int CHG  = 4;
    localparam int TMO  = 255;

    typedef struct {
        int lane;
        int err;
        int mcyc;
        int ccyc;
        int gcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ptr_m   = 0;
    exp_t sb[$];

    vend_dispense_sched_if #(.N_LANE(N)) bus();

    vend_dispense_sched #(
        .N_LANE(N), .DISP_CYC(DISP), .CHG_CYC(CHG), .TMO_CYC(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: accumulate per-transaction activity, compare on each ack
    initial begin : monitor
        int   g_cyc;
        int   m_cyc;
        int   c_cyc;
        bit   bad;
        exp_t e;
        g_cyc = 0; m_cyc = 0; c_cyc = 0; bad = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                g_cyc = 0; m_cyc = 0; c_cyc = 0; bad = 1'b0;
            end else begin
                if (bus.motor_on && bus.change_on) bad = 1'b1;
                if (bus.gnt == '0 && (bus.motor_on || bus.change_on)) bad = 1'b1;
                if (bus.ack != '0) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ack: got ack=%b, expected no ack", bus.ack);
                    end else begin
                        e = sb.pop_front();
                        chk("ack_lane",      int'(bus.ack),       1 << e.lane);
                        chk("gnt_at_ack",    int'(bus.gnt),       1 << e.lane);
                        chk("err",           int'(bus.err),       e.err);
                        chk("motor_cycles",  m_cyc,               e.mcyc);
                        chk("change_cycles", c_cyc,               e.ccyc);
                        chk("grant_wait",    g_cyc,               e.gcyc);
                        chk("actuator_rule", int'(bad),           0);
                        chk("busy_at_ack",   int'(bus.busy),      1);
                        chk("motor_at_ack",  int'(bus.motor_on),  0);
                    end
                    g_cyc = 0; m_cyc = 0; c_cyc = 0; bad = 1'b0;
                end else if (bus.gnt != '0) begin
                    if (bus.motor_on)       m_cyc++;
                    else if (bus.change_on) c_cyc++;
                    else                    g_cyc++;
                end
            end
        end
    end

    // One batch: predict service order, then emulate lanes until all served
    task automatic run_batch(input logic [3:0] mask, input logic [7:0] codes,
                             input int reraise, input int hold, input bit scramble);
        int         total, cnt, lane, held, gl, rr;
        bit         first, done;
        exp_t       e;
        logic [3:0] pend;
        total = $countones(mask) + reraise;
        cnt   = 0;
        lane  = ptr_m;
        first = 1'b1;
        rr    = reraise;
        while (cnt < total) begin
            if (mask[lane]) begin
                e.lane = lane;
                e.err  = 0;
                e.mcyc = DISP;
                e.ccyc = (codes[2*lane +: 2] == 2'b01) ? CHG : 0;
                e.gcyc = first ? hold + 1 : 1;
`ifdef VEND_TIMEOUT_EN
                if (first && (hold + 1 > TMO)) begin
                    e.err = 1; e.mcyc = 0; e.ccyc = 0; e.gcyc = TMO;
                end
`endif
                sb.push_back(e);
                cnt++;
                ptr_m = (lane + 1) % N;
                first = 1'b0;
            end
            lane = (lane + 1) % N;
        end

        bus.amt        = codes;
        bus.req        = mask;
        bus.mech_ready = (hold == 0);
        held = 0;
        pend = '0;
        done = 1'b0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            bus.req = bus.req | pend;
            pend    = '0;
            if (bus.ack != '0) begin
                bus.req = bus.req & ~bus.ack;
                if (rr > 0) begin
                    pend = bus.ack;
                    rr--;
                end
            end else if (bus.gnt != '0) begin
                if (!bus.mech_ready) begin
                    if (held >= hold) bus.mech_ready = 1'b1;
                    else              held++;
                end
                gl = 0;
                for (int i = 0; i < N; i++) if (bus.gnt[i]) gl = i;
                if (scramble && $urandom_range(0, 3) == 0)
                    bus.amt[2*gl +: 2] = bus.amt[2*gl +: 2] ^ 2'($urandom_range(1, 3));
                if (scramble && $urandom_range(0, 7) == 0)
                    bus.req[gl] = 1'b0;
            end
            done = (bus.req == '0) && (pend == '0) && (sb.size() == 0);
        end
        chk("batch_complete", int'(done), 1);
        bus.mech_ready = 1'b1;
    endtask

    // Stimulus sequence
    initial begin : stim
        bit seen;
        bus.req        = '0;
        bus.amt        = '0;
        bus.mech_ready = 1'b1;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_gnt",    int'(bus.gnt),       0);
        chk("rst_ack",    int'(bus.ack),       0);
        chk("rst_motor",  int'(bus.motor_on),  0);
        chk("rst_change", int'(bus.change_on), 0);
        chk("rst_busy",   int'(bus.busy),      0);
        chk("rst_err",    int'(bus.err),       0);
        rst = 1'b0;
        @(negedge clk);

        run_batch(4'b0001, 8'h00, 0, 0, 1'b0);
        run_batch(4'b0100, 8'h10, 0, 0, 1'b0);
        run_batch(4'b1111, 8'b01_00_01_00, 1, 0, 1'b0);
        run_batch(4'b0010, 8'h00, 0, 20, 1'b0);

        for (int t = 0; t < 15; t++)
            run_batch(4'($urandom_range(1, 15)), 8'($urandom), 0, 0, 1'($urandom_range(0, 1)));

        // Reset in the middle of a dispense, then pointer must restart at lane 0
        run_batch(4'b0100, 8'h00, 0, 0, 1'b0);
        bus.amt = '0;
        bus.req = 4'b1000;
        seen    = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.motor_on) seen = 1'b1;
        end
        chk("motor_before_reset", int'(seen), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_motor",  int'(bus.motor_on),  0);
        chk("async_rst_gnt",    int'(bus.gnt),       0);
        chk("async_rst_busy",   int'(bus.busy),      0);
        chk("async_rst_change", int'(bus.change_on), 0);
        bus.req = '0;
        sb.delete();
        ptr_m = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_batch(4'b1111, 8'($urandom), 0, 0, 1'b0);

        // Long mech_ready stall: abort with err when enabled, plain wait otherwise
`ifdef VEND_TIMEOUT_EN
        run_batch(4'b0001, 8'h01, 0, TMO + 100, 1'b0);
`else
        run_batch(4'b0001, 8'h01, 0, 300, 1'b0);
`endif
        run_batch(4'b0110, 8'($urandom), 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("idle_busy",   int'(bus.busy),  0);
        chk("sb_drained",  sb.size(),       0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
